// File: rtl/seq_detector_param_if.sv
// Serial detector bus: stream input, runtime pattern configuration, match status.
// With SEQDET_STICKY_EN defined, the bus also carries match_ack/match_flag.
interface seq_detector_param_if #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
);
  logic             data_in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             overlap;
  logic             cnt_clr;
  logic             data_out;
  logic [PAT_W-1:0] shift_regs;
  logic [CNT_W-1:0] match_count;
  logic             cnt_sat;
`ifdef SEQDET_STICKY_EN
  logic             match_ack;
  logic             match_flag;

  modport master (
    output data_in, in_valid, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr, match_ack,
    input  data_out, shift_regs, match_count, cnt_sat, match_flag
  );
  modport slave (
    input  data_in, in_valid, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr, match_ack,
    output data_out, shift_regs, match_count, cnt_sat, match_flag
  );
`else
  modport master (
    output data_in, in_valid, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr,
    input  data_out, shift_regs, match_count, cnt_sat
  );
  modport slave (
    input  data_in, in_valid, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr,
    output data_out, shift_regs, match_count, cnt_sat
  );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with maskable runtime pattern and saturating match counter.
// Optional sticky match flag with acknowledge is enabled by defining SEQDET_STICKY_EN.
module seq_detector_param #(
  parameter int               PAT_W     = 6,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(6'b101011)
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  window_q;
  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  mask_q;
  logic [FILL_W-1:0] fill_q;
  logic              data_out_q;
  logic [CNT_W-1:0]  count_q;
  logic              sat_q;

  logic              shift_en;
  logic [PAT_W-1:0]  next_window;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;
  logic              sat_next;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    shift_en    = bus.in_valid & ~bus.cfg_load;
    next_window = {window_q[PAT_W-2:0], bus.data_in};
    fill_inc    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit         = shift_en && (fill_inc == FILL_FULL) && (mask_q != '0) &&
                  (((next_window ^ pattern_q) & mask_q) == '0);

    // Clear takes precedence, so a coincident match counts from zero.
    cnt_base = bus.cnt_clr ? '0 : count_q;
    sat_next = bus.cnt_clr ? 1'b0 : sat_q;
    cnt_next = cnt_base;
    if (hit && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_W'(1);
      if (cnt_next == CNT_MAX) sat_next = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: pattern and mask are reset too, so detection is well defined straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q   <= '0;
      fill_q     <= '0;
      pattern_q  <= PAT_RESET;
      mask_q     <= '1;
      data_out_q <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      data_out_q <= hit;
      count_q    <= cnt_next;
      sat_q      <= sat_next;
      if (bus.cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        mask_q    <= bus.cfg_mask;
        window_q  <= '0;
        fill_q    <= '0;
      end else if (bus.in_valid) begin
        window_q <= next_window;
        // Non-overlapping mode demands a full set of fresh bits after each match.
        fill_q   <= (hit && !bus.overlap) ? '0 : fill_inc;
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.shift_regs  = window_q;
  assign bus.match_count = count_q;
  assign bus.cnt_sat     = sat_q;

`ifdef SEQDET_STICKY_EN
  logic flag_q;

  // A match wins over a coincident acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             flag_q <= 1'b0;
    else if (hit)          flag_q <= 1'b1;
    else if (bus.match_ack) flag_q <= 1'b0;
  end

  assign bus.match_flag = flag_q;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial sequence detector, successor to the fixed 6-bit hard-coded shift-register detector.
- Shifts a qualified 1-bit serial stream into a PAT_W-bit window and compares it against a runtime-loadable pattern with per-bit don't-care mask.
- Supports overlapping and non-overlapping detection, and counts matches in a saturating counter.
- Sits between the serial input sampler and the status/interrupt logic.

Parameters:
- PAT_W, 6, pattern/window width in bits (2..32)
- CNT_W, 8, match counter width (1..32)
- PAT_RESET, 6'b101011, pattern value after reset (PAT_W bits)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  1  serial data bit
- in_valid  input  1  data_in qualifier; bit shifted only when high
- cfg_load  input  1  latch cfg_pattern/cfg_mask and restart detection
- cfg_pattern  input  PAT_W  new pattern; MSB = first-received bit
- cfg_mask  input  PAT_W  1 = compare bit, 0 = don't care
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_count and cnt_sat
- data_out  output  1  one-cycle match pulse (registered)
- shift_regs  output  PAT_W  current window, bit 0 = newest bit
- match_count  output  CNT_W  saturating count of matches
- cnt_sat  output  1  sticky, set when match_count reaches all-ones

Behaviour:
- Reset (async, active-high):
  - shift_regs=0, fill=0, data_out=0, match_count=0, cnt_sat=0.
  - Pattern register=PAT_RESET, mask register=all ones.
- Shift: on an edge with in_valid=1 and cfg_load=0, shift_regs <= {shift_regs[PAT_W-2:0], data_in}; fill <= min(fill+1, PAT_W).
- Fill counter, clog2(PAT_W+1) bits: the window is armed when fill==PAT_W after the shift.
- Match:
  - Condition: in_valid=1 and cfg_load=0 on the edge, the post-shift window is armed, ((next_window XOR pattern) AND mask)==0, and mask!=0.
  - data_out is registered and high for exactly the one cycle following that edge; otherwise it is 0.
  - Latency: a match on the last pattern bit sampled at edge k gives data_out=1 between edges k and k+1.
- Mask all zeros disables detection; data_out is never asserted.
- overlap=1: fill stays at PAT_W after a match, so consecutive matches may share bits.
- overlap=0: a match sets fill to 0, so the next match needs PAT_W fresh valid bits. shift_regs still shifts normally.
- in_valid=0: window, fill and data_out path hold; data_out is 0 that cycle.
- cfg_load:
  - Latches cfg_pattern/cfg_mask and clears shift_regs and fill.
  - No match is evaluated that cycle; a coincident in_valid bit is dropped.
  - match_count is unaffected.
- Counter:
  - Each match increments match_count, which holds at all-ones once reached.
  - cnt_sat is set on the edge where match_count becomes all-ones and stays set until cnt_clr or reset.
  - If cnt_clr coincides with a match, clear applies first: match_count=1, cnt_sat=0.
  - If cnt_clr is high with no match: match_count=0, cnt_sat=0.
- overlap may change at any time and takes effect on the next match evaluation.
- Reset mid-stream discards partial window contents; detection restarts from fill=0.

Optional Feature:
- Macro SEQDET_STICKY_EN.
- Defined:
  - Adds input match_ack (1 bit) and output match_flag (1 bit, reset 0).
  - match_flag is set by any match and held until an edge with match_ack=1 and no coincident match.
  - Match and ack on the same edge leave the flag set.
- Not defined: neither port exists, and behaviour is only data_out/match_count.

Test Plan:
- Defaults, overlap=1, stream 1,0,1,0,1,1 valid back-to-back -> data_out pulses once in the cycle after the 6th bit; match_count=1; shift_regs=6'b101011.
- Load pattern 6'b101010, mask all ones, overlap=1, stream 1,0,1,0,1,0,1,0 -> pulses after bits 6 and 8; match_count=2. Same with overlap=0 -> pulse after bit 6 only; match_count=1.
- Pattern 101011, mask 6'b111100, stream 1,0,1,0,0,0 -> match. Then load mask 0 and send 24 bits -> no pulse.
- in_valid gaps: bits of 101011 with in_valid=0 for 3 cycles between bits 3 and 4 -> a single pulse after bit 6; data_out=0 during gaps. cfg_load after bit 4 -> no match until 6 new bits.
- CNT_W=2, 4 overlapping matches -> count 1,2,3,3; cnt_sat=1 from the 3rd match. cnt_clr with a coincident match -> count=1, cnt_sat=0.
- Reset asserted asynchronously after 5 bits of 101011, then released and the 6th bit sent -> no pulse; all outputs 0. With SEQDET_STICKY_EN: match_flag set after a match, cleared by match_ack, held when ack coincides with a new match.
